// File: rtl/dmem_rr_arbiter_pkg.sv
// dmem_rr_arbiter_pkg
// Purpose : shared constants and types for the four-port data-memory
//           round-robin arbiter (port count, port-id width, vector types)
//           plus a small helper that turns a port id into a one-hot vector.
// Ports   : none (package).
package dmem_rr_arbiter_pkg;

   localparam int NPORTS    = 4;
   localparam int PORT_ID_W = 2;

   typedef logic [NPORTS-1:0]    gnt_vec_t;
   typedef logic [NPORTS-1:0]    err_vec_t;
   typedef logic [PORT_ID_W-1:0] port_id_t;

   // Expands a port id into the matching one-hot port vector.
   function automatic gnt_vec_t idToOneHot(port_id_t id);
      gnt_vec_t vec;
      vec     = '0;
      vec[id] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// dmem_rr_arbiter_if
// Purpose : bundles the core-side request/response bus and the downstream
//           single-port memory bus of the arbiter.
// Signals : req/we/addr/wdata  - per-core requests (port i at [i*W +: W])
//           gnt/rvalid/err     - one-hot per-core accept, read-valid, error
//           rdata              - shared read data
//           mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory strobe bus
// Modports: master - the cores and the memory (drive requests, read data)
//           slave  - the arbiter
interface dmem_rr_arbiter_if
   import dmem_rr_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic [NPORTS-1:0]    req;
   logic [NPORTS-1:0]    we;
   logic [NPORTS*AW-1:0] addr;
   logic [NPORTS*DW-1:0] wdata;
   gnt_vec_t             gnt;
   logic [NPORTS-1:0]    rvalid;
   logic [DW-1:0]        rdata;
   err_vec_t             err;
   logic                 mem_en;
   logic                 mem_we;
   logic [AW-3:0]        mem_addr;
   logic [DW-1:0]        mem_wdata;
   logic [DW-1:0]        mem_rdata;

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dmem_rr_arbiter_rr_pick4.sv
// rr_pick4
// Purpose : combinational four-way round-robin picker. The search begins at
//           the port after ptr_i and wraps, so the last-granted port has the
//           lowest priority.
// Ports   : req_i   - request vector
//           ptr_i   - id of the most recently granted port
//           gnt_o   - one-hot grant (all zero when nothing requests)
//           gntId_o - id of the granted port (ptr_i when nothing requests)
module rr_pick4
   import dmem_rr_arbiter_pkg::*;
(
   input  gnt_vec_t req_i,
   input  port_id_t ptr_i,
   output gnt_vec_t gnt_o,
   output port_id_t gntId_o
);

   logic     found;
   port_id_t cand;

   // Walk ptr+1, ptr+2, ptr+3, ptr+4 (== ptr) with 2-bit wrap; the first
   // requesting port wins.
   always_comb begin
      gnt_o   = '0;
      gntId_o = ptr_i;
      found   = 1'b0;
      cand    = ptr_i;
      for (int k = 1; k <= NPORTS; k++) begin
         cand = ptr_i + port_id_t'(k);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gntId_o     = cand;
         end
      end
   end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
// Purpose : shares one single-port data memory among four cores. One access
//           is accepted per cycle in round-robin order; legal reads return
//           data one cycle after the grant, illegal accesses (misaligned or
//           beyond the memory depth) are granted but flagged with err one
//           cycle later and never reach the memory.
// Ports   : clk_i  - sole clock, rising edge
//           rst_ni - asynchronous active-low reset
//           bus    - arbiter side of dmem_rr_arbiter_if (cores + memory)
module dmem_rr_arbiter
   import dmem_rr_arbiter_pkg::*;
#(
   parameter int NPORTS      = 4,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   dmem_rr_arbiter_if.slave  bus
);

   localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH_WORDS);

   gnt_vec_t      pickGnt;
   gnt_vec_t      gntVec;
   port_id_t      pickId;
   port_id_t      ptr_q, ptr_d;
   logic          anyGnt;
   logic          legal;
   logic          selWe;
   logic [AW-1:0] selAddr;
   logic [DW-1:0] selWdata;
   logic          respValid_q, respValid_d;
   port_id_t      respId_q, respId_d;
   logic          errValid_q, errValid_d;
   port_id_t      errId_q, errId_d;

   rr_pick4 u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .gnt_o   (pickGnt),
      .gntId_o (pickId)
   );

   // Grants are gated by reset directly so nothing is accepted while the
   // reset is held, even between clock edges.
   always_comb begin
      gntVec   = rst_ni ? pickGnt : '0;
      anyGnt   = |gntVec;
      selAddr  = bus.addr[pickId*AW +: AW];
      selWdata = bus.wdata[pickId*DW +: DW];
      selWe    = bus.we[pickId];
      legal    = (selAddr[1:0] == 2'b00) &&
                 ({2'b00, selAddr[AW-1:2]} < DEPTH_LIM);
   end

   // Memory strobe for the winning port, plus next-state for the pointer and
   // the one-deep read/error response trackers. Only one access is granted
   // per cycle, so one tracker entry of each kind is enough for full rate.
   always_comb begin
      bus.gnt       = gntVec;
      bus.mem_en    = anyGnt && legal;
      bus.mem_we    = anyGnt && legal && selWe;
      bus.mem_addr  = selAddr[AW-1:2];
      bus.mem_wdata = selWdata;
      ptr_d         = anyGnt ? pickId : ptr_q;
      respValid_d   = anyGnt && legal && !selWe;
      respId_d      = pickId;
      errValid_d    = anyGnt && !legal;
      errId_d       = pickId;
   end

   // Response outputs; rdata is forced to zero whenever no read completes.
   always_comb begin
      bus.rvalid = respValid_q ? idToOneHot(respId_q) : '0;
      bus.rdata  = respValid_q ? bus.mem_rdata : '0;
      bus.err    = errValid_q ? idToOneHot(errId_q) : '0;
   end

   // Pointer resets to 3 so that port 0 is searched first after reset; the
   // trackers reset to idle, which also drops any read in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q       <= port_id_t'(3);
         respValid_q <= 1'b0;
         respId_q    <= '0;
         errValid_q  <= 1'b0;
         errId_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         respValid_q <= respValid_d;
         respId_q    <= respId_d;
         errValid_q  <= errValid_d;
         errId_q     <= errId_d;
      end
   end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb_dmem_rr_arbiter
// Purpose : directed self-checking bench for dmem_rr_arbiter with a small
//           behavioural single-port memory (one-cycle read latency).
// Ports   : none (top-level bench).
module tb_dmem_rr_arbiter;
   import dmem_rr_arbiter_pkg::*;

   logic clk;
   logic rst_n;
   int   checkCount = 0;
   int   passCount  = 0;

   logic [31:0] memArray [0:1023];
   logic [3:0]  expSeq [8];

   dmem_rr_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_rr_arbiter #(
      .NPORTS      (4),
      .AW          (32),
      .DW          (32),
      .DEPTH_WORDS (1024)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream memory: writes land on the strobe edge, reads appear on
   // mem_rdata after the strobe edge.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we)
            memArray[bus.mem_addr[9:0]] <= bus.mem_wdata;
         else
            bus.mem_rdata <= memArray[bus.mem_addr[9:0]];
      end
   end

   // Counts one comparison and reports it when it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                  tag, observed, expected);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request vector and one port's access fields, then let the
   // combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] we,
                                input int port, input logic [31:0] addr,
                                input logic [31:0] wdata);
      bus.req                   = req;
      bus.we                    = we;
      bus.addr[port*32 +: 32]   = addr;
      bus.wdata[port*32 +: 32]  = wdata;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         memArray[i] = 32'h0;
      memArray[5]   = 32'hDEADBEEF;
      bus.mem_rdata = 32'h0;
      expSeq        = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                        4'b0001, 4'b0010, 4'b0100, 4'b1000};
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      rst_n     = 1'b0;

      // Reset holds everything quiet even with all ports requesting.
      repeat (2) @(posedge clk);
      #1;
      bus.req = 4'hF;
      #1;
      checkOutput("reset_gnt",    32'(bus.gnt),    32'h0);
      checkOutput("reset_mem_en", 32'(bus.mem_en), 32'h0);
      checkOutput("reset_rvalid", 32'(bus.rvalid), 32'h0);
      checkOutput("reset_err",    32'(bus.err),    32'h0);
      checkOutput("reset_rdata",  bus.rdata,       32'h0);
      bus.req = '0;
      rst_n   = 1'b1;
      tick();

      // Port 2 reads word 5.
      applyStimulus(4'b0100, 4'b0000, 2, 32'h14, 32'h0);
      checkOutput("p2rd_gnt",      32'(bus.gnt),      32'h4);
      checkOutput("p2rd_mem_en",   32'(bus.mem_en),   32'h1);
      checkOutput("p2rd_mem_we",   32'(bus.mem_we),   32'h0);
      checkOutput("p2rd_mem_addr", 32'(bus.mem_addr), 32'h5);
      tick();
      bus.req = '0;
      #1;
      checkOutput("p2rd_rvalid", 32'(bus.rvalid), 32'h4);
      checkOutput("p2rd_rdata",  bus.rdata,       32'hDEADBEEF);

      // Port 1 writes 0x40, then port 3 reads it back.
      applyStimulus(4'b0010, 4'b0010, 1, 32'h40, 32'h12345678);
      checkOutput("p1wr_gnt",       32'(bus.gnt),      32'h2);
      checkOutput("p1wr_mem_en",    32'(bus.mem_en),   32'h1);
      checkOutput("p1wr_mem_we",    32'(bus.mem_we),   32'h1);
      checkOutput("p1wr_mem_addr",  32'(bus.mem_addr), 32'h10);
      checkOutput("p1wr_mem_wdata", bus.mem_wdata,     32'h12345678);
      tick();
      bus.req = '0;
      bus.we  = '0;
      #1;
      checkOutput("p1wr_no_rvalid", 32'(bus.rvalid), 32'h0);
      checkOutput("p1wr_rdata0",    bus.rdata,       32'h0);
      applyStimulus(4'b1000, 4'b0000, 3, 32'h40, 32'h0);
      checkOutput("p3rd_gnt",      32'(bus.gnt),      32'h8);
      checkOutput("p3rd_mem_addr", 32'(bus.mem_addr), 32'h10);
      checkOutput("p3rd_mem_we",   32'(bus.mem_we),   32'h0);
      tick();
      bus.req = '0;
      #1;
      checkOutput("p3rd_rvalid", 32'(bus.rvalid), 32'h8);
      checkOutput("p3rd_rdata",  bus.rdata,       32'h12345678);

      // Back-to-back reads from ports 0 and 1.
      applyStimulus(4'b0001, 4'b0000, 0, 32'h14, 32'h0);
      checkOutput("b2b_gnt0", 32'(bus.gnt), 32'h1);
      tick();
      applyStimulus(4'b0010, 4'b0000, 1, 32'h40, 32'h0);
      checkOutput("b2b_gnt1",    32'(bus.gnt),    32'h2);
      checkOutput("b2b_rvalid0", 32'(bus.rvalid), 32'h1);
      checkOutput("b2b_rdata0",  bus.rdata,       32'hDEADBEEF);
      tick();
      bus.req = '0;
      #1;
      checkOutput("b2b_rvalid1", 32'(bus.rvalid), 32'h2);
      checkOutput("b2b_rdata1",  bus.rdata,       32'h12345678);

      // Misaligned, then out-of-range accesses from port 0.
      applyStimulus(4'b0001, 4'b0000, 0, 32'h3, 32'h0);
      checkOutput("misal_gnt",    32'(bus.gnt),    32'h1);
      checkOutput("misal_mem_en", 32'(bus.mem_en), 32'h0);
      tick();
      applyStimulus(4'b0001, 4'b0000, 0, 32'h1000, 32'h0);
      checkOutput("misal_err",     32'(bus.err),    32'h1);
      checkOutput("misal_rvalid",  32'(bus.rvalid), 32'h0);
      checkOutput("range_gnt",     32'(bus.gnt),    32'h1);
      checkOutput("range_mem_en",  32'(bus.mem_en), 32'h0);
      tick();
      bus.req  = '0;
      bus.addr = '0;
      #1;
      checkOutput("range_err",  32'(bus.err), 32'h1);
      tick();
      checkOutput("err_clears", 32'(bus.err), 32'h0);

      // Fresh reset, then all four ports request for eight cycles.
      rst_n = 1'b0;
      #1;
      rst_n     = 1'b1;
      bus.addr  = '0;
      bus.we    = '0;
      bus.req   = 4'hF;
      #1;
      for (int c = 0; c < 8; c++) begin
         checkOutput($sformatf("rr_gnt%0d", c), 32'(bus.gnt), 32'(expSeq[c]));
         if (c > 0)
            checkOutput($sformatf("rr_rvalid%0d", c), 32'(bus.rvalid),
                        32'(expSeq[c-1]));
         tick();
      end
      bus.req = '0;
      #1;
      checkOutput("rr_rvalid_last", 32'(bus.rvalid), 32'h8);

      // Reset dropped right after a read grant from port 2.
      applyStimulus(4'b0100, 4'b0000, 2, 32'h14, 32'h0);
      checkOutput("rstrd_gnt", 32'(bus.gnt), 32'h4);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("rstrd_rvalid", 32'(bus.rvalid), 32'h0);
      checkOutput("rstrd_rdata",  bus.rdata,       32'h0);
      checkOutput("rstrd_gnt0",   32'(bus.gnt),    32'h0);
      tick();
      rst_n   = 1'b1;
      bus.req = '0;
      tick();
      checkOutput("rstrd_no_late_rvalid", 32'(bus.rvalid), 32'h0);
      bus.req = 4'hF;
      #1;
      checkOutput("rstrd_ptr_port0", 32'(bus.gnt), 32'h1);
      bus.req = '0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
